alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 15 +
 rtl/alu_arbiter_alu.sv | 30 +++
 rtl/alu_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: state type, ALU opcodes and requester count shared by the arbiter and its ALU
package alu_arbiter_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: combinational ALU; srca_i/srcb_i operands, op_i operation code, result_o result (0 for undefined codes)
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    srca_i,
  input  logic [DATA_WIDTH-1:0]    srcb_i,
  input  logic [OPCODE_LENGTH-1:0] op_i,
  output logic [DATA_WIDTH-1:0]    result_o
);
  logic [4:0] sh;
  assign sh = srcb_i[4:0];
  always_comb begin
    case (op_i)
      OP_AND:  result_o = srca_i & srcb_i;
      OP_SUB:  result_o = srca_i - srcb_i;
      OP_ADD:  result_o = srca_i + srcb_i;
      OP_OR:   result_o = srca_i | srcb_i;
      OP_XOR:  result_o = srca_i ^ srcb_i;
      OP_SLT:  result_o = DATA_WIDTH'($signed(srca_i) < $signed(srcb_i));
      OP_EQ:   result_o = DATA_WIDTH'(srca_i == srcb_i);
      OP_SLL:  result_o = srca_i << sh;
      OP_SRL:  result_o = srca_i >> sh;
      OP_SRA:  result_o = DATA_WIDTH'($signed(srca_i) >>> sh);
      default: result_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter serving two requesters one operation at a time through a shared ALU
//   req_valid/req_ready, req_srca_*/req_srcb_*/req_op_*: per-requester operation handshake
//   resp_valid/resp_ready, resp_result: result handshake for the owning requester
//   busy: high whenever not idle
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [DATA_WIDTH-1:0]    req_srca_0,
  input  logic [DATA_WIDTH-1:0]    req_srca_1,
  input  logic [DATA_WIDTH-1:0]    req_srcb_0,
  input  logic [DATA_WIDTH-1:0]    req_srcb_1,
  input  logic [OPCODE_LENGTH-1:0] req_op_0,
  input  logic [OPCODE_LENGTH-1:0] req_op_1,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_result,
  output logic                     busy
);
  state_t                   state_q, state_d;
  logic                     ptr_q, ptr_d, id_q, id_d, gnt, take;
  logic [DATA_WIDTH-1:0]    srca_q, srca_d, srcb_q, srcb_d, result_q, result_d, alu_y;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  // requester 1 wins when alone, or when both ask and it holds priority
  assign gnt = req_valid[1] & (~req_valid[0] | ptr_q);
  // gated by reset so req_ready drops immediately on assertion
  assign take = (state_q == IDLE) && (|req_valid) && !reset;
  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_alu (
    .srca_i  (srca_q),
    .srcb_i  (srcb_q),
    .op_i    (op_q),
    .result_o(alu_y)
  );
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    op_d        = op_q;
    result_d    = result_q;
    req_ready   = take ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    resp_valid  = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    resp_result = result_q;
    busy        = state_q != IDLE;
    case (state_q)
      IDLE: if (take) begin
        state_d = EXEC;
        ptr_d   = ~gnt;
        id_d    = gnt;
        srca_d  = gnt ? req_srca_1 : req_srca_0;
        srcb_d  = gnt ? req_srcb_1 : req_srcb_0;
        op_d    = gnt ? req_op_1 : req_op_0;
      end
      EXEC: begin
        state_d  = RESP;
        result_d = alu_y;
      end
      RESP: state_d = resp_ready[id_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      srca_q   <= '0;
      srcb_q   <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end
endmodule
